wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter PC_INC, default 4, meaning the link increment (2 for compressed).
REQ-003 SHALL have parameter LQ_DEPTH, default 2, meaning late-result queue entries (power of 2, >=2).
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 in_valid  in  1  main pipeline has a write-back op
 in_ready  out  1  unit accepts main op this cycle
 in_wb_sel  in  3  0 ALU, 1 LOAD, 2 PC+PC_INC, 3 CSR, 4-7 no write
 in_rd  in  5  destination register
 in_pc  in  XLEN  instruction PC
 in_alu  in  XLEN  ALU result
 in_load  in  32  raw aligned load word
 in_load_fn  in  3  RISC-V load funct3 (LB, LH, LW, LBU, LHU)
 in_addr_lo  in  2  load address bits [1:0]
 in_csr  in  XLEN  CSR read value
 md_valid  in  1  long-latency (mul/div) result valid
 md_ready  out  1  late queue can accept
 md_rd  in  5  late destination register
 md_data  in  XLEN  late result
 rf_we  out  1  register-file write enable (registered)
 rf_waddr  out  5  write address (registered)
 rf_wdata  out  XLEN  write data (registered)

Function
REQ-005 SHALL select write data: ALU->in_alu; LOAD->extracted load; PC->in_pc+PC_INC modulo 2^XLEN; CSR->in_csr.
REQ-006 SHALL extract loads: LB byte at in_addr_lo, sign-extended; LBU same, zero-extended; LH half at in_addr_lo[1], sign-extended; LHU zero-extended; LW whole word, sign-extended to XLEN; other funct3 -> 0.
REQ-007 SHALL present main results on rf_* exactly one cycle after the in_valid&&in_ready handshake.
REQ-008 SHALL push each md_valid&&md_ready beat into a FIFO late queue of LQ_DEPTH entries.
REQ-009 SHALL drive md_ready = queue not full, from registered occupancy only.
REQ-010 SHALL drive in_ready = queue not full.
REQ-011 SHALL arbitrate the single write port per cycle: an accepted main op whose wb_sel is 0-3 wins; otherwise the queue head, if any, drains to rf_*.
REQ-012 SHALL, when the queue is full, hold in_ready low, so that the head drains that cycle; the queue therefore never starves.
REQ-013 SHALL allow enqueue and dequeue in the same cycle, with occupancy unchanged.
REQ-014 SHALL wrap queue pointers modulo LQ_DEPTH, with a separate count of width clog2(LQ_DEPTH)+1.
REQ-015 SHALL force rf_we=0 for rd==0 writes (main or late) while still consuming the op/entry.
REQ-016 SHALL force rf_we=0 in any cycle with no winner; rf_waddr/rf_wdata then hold their previous values.
REQ-017 SHALL give a late result a minimum latency of 2 cycles from handshake to rf_we.
REQ-018 SHALL never reorder late results among themselves.

Reset
REQ-019 SHALL, while rst_n=0, asynchronously clear rf_we, rf_waddr and rf_wdata to 0 and empty the queue, with pointers and count at 0.
REQ-020 SHALL drop queue contents on reset assertion mid-operation; in_ready=1 and md_ready=1 once reset is held.
REQ-021 SHALL deassert reset without a glitch on rf_we; the first write occurs no earlier than the cycle after the first post-reset handshake.

Structure
REQ-022 SHALL take wb_sel_e (ALU, LOAD, PC, CSR, NONE) and load funct3 constants from shared package wb_pkg.
REQ-023 SHALL implement the late queue as sub-module wb_late_fifo, parametrised by width (5+XLEN) and depth.
REQ-024 SHALL contain no latches; all state on clk with asynchronous rst_n.

Verification
REQ-025 SHALL cover: sel=2, pc=0xFFFFFFFC, XLEN=32 -> next cycle rf_we=1, rf_wdata=0x00000000 (wrap).
REQ-026 SHALL cover: LB, in_load=0x80FF7F01, addr_lo=3 -> rf_wdata=0xFFFFFF80; LHU addr_lo=2 -> 0x000080FF.
REQ-027 SHALL cover: md beat rd=5, data=0x1234, with main idle -> rf_we=1, waddr=5, wdata=0x1234 two cycles later.
REQ-028 SHALL cover: main ALU writes every cycle while 3 md beats arrive (LQ_DEPTH=2) -> md_ready low after 2, in_ready low for one cycle, queue drains in order, no beat is lost.
REQ-029 SHALL cover: main rd=0, sel=0 -> rf_we=0, with the queue head draining that cycle if non-empty.
REQ-030 SHALL cover: rst_n pulsed low with the queue full -> rf_we=0 immediately, md_ready=1, and no stale entry is written after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back definitions: result selector encoding, load funct3 codes
// and the load-word extraction helper.
package wb_pkg;
    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_LOAD = 3'd1,
        WB_PC   = 3'd2,
        WB_CSR  = 3'd3,
        WB_NONE = 3'd4
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Result is 64 bits wide so both XLEN=32 and XLEN=64 callers can truncate.
    function automatic logic [63:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  fn,
                                                 input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (fn)
            F3_LB:   load_extract = {{56{b[7]}}, b};
            F3_LBU:  load_extract = {56'd0, b};
            F3_LH:   load_extract = {{48{h[15]}}, h};
            F3_LHU:  load_extract = {48'd0, h};
            F3_LW:   load_extract = {{32{word[31]}}, word};
            default: load_extract = 64'd0;
        endcase
    endfunction
endpackage

// File: rtl/wb_late_fifo.sv
// Small FIFO holding long-latency results until the write port is free.
module wb_late_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Callers guard push with !full and pop with !empty; DEPTH is a power of
    // two so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/wb_unit.sv
// Write-back stage: selects main-pipe result and arbitrates the single
// register-file write port against a queue of late mul/div results.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_INC   = 4,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_wb_sel,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [31:0]     in_load,
    input  logic [2:0]      in_load_fn,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_csr,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);
    localparam int QW = 5 + XLEN;

    logic            full, empty, push, pop, main_win;
    logic [QW-1:0]   head;
    logic [63:0]     ld_ext;
    logic [XLEN-1:0] main_data;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    assign in_ready = !full;
    assign md_ready = !full;
    assign push     = md_valid && !full;
    // An rd==0 main op needs no port, so the queue head may use it instead.
    assign main_win = in_valid && in_ready && !in_wb_sel[2] && (in_rd != 5'd0);
    assign pop      = !empty && !main_win;
    assign ld_ext   = load_extract(in_load, in_load_fn, in_addr_lo);

    wb_late_fifo #(.W(QW), .DEPTH(LQ_DEPTH)) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({md_rd, md_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        case (in_wb_sel)
            WB_ALU:  main_data = in_alu;
            WB_LOAD: main_data = ld_ext[XLEN-1:0];
            WB_PC:   main_data = in_pc + XLEN'(PC_INC);
            WB_CSR:  main_data = in_csr;
            default: main_data = '0;
        endcase
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (main_win) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = main_data;
        end else if (pop) begin
            rf_we_d    = (head[QW-1 -: 5] != 5'd0);
            rf_waddr_d = head[QW-1 -: 5];
            rf_wdata_d = head[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: result select, load extraction, late queue
// arbitration/back-pressure and reset behaviour.
module tb_wb_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_wb_sel;
    logic [4:0]  in_rd;
    logic [31:0] in_pc, in_alu, in_csr;
    logic [31:0] in_load;
    logic [2:0]  in_load_fn;
    logic [1:0]  in_addr_lo;
    logic        md_valid, md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(32), .PC_INC(4), .LQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_wb_sel(in_wb_sel),
        .in_rd(in_rd), .in_pc(in_pc), .in_alu(in_alu), .in_load(in_load),
        .in_load_fn(in_load_fn), .in_addr_lo(in_addr_lo), .in_csr(in_csr),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic main_op(input logic v, input logic [2:0] sel, input logic [4:0] rd,
                           input logic [31:0] alu);
        in_valid  = v;
        in_wb_sel = sel;
        in_rd     = rd;
        in_alu    = alu;
    endtask

    task automatic md_op(input logic v, input logic [4:0] rd, input logic [31:0] d);
        md_valid = v;
        md_rd    = rd;
        md_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
        chk({tag, ".we"}, 64'(rf_we), 64'(we));
        chk({tag, ".addr"}, 64'(rf_waddr), 64'(a));
        chk({tag, ".data"}, 64'(rf_wdata), 64'(d));
    endtask

    initial begin
        rst_n = 1'b0;
        main_op(1'b0, 3'd4, 5'd0, 32'd0);
        md_op(1'b0, 5'd0, 32'd0);
        in_pc = '0; in_csr = '0; in_load = '0; in_load_fn = '0; in_addr_lo = '0;
        #1;
        chk_wr("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.md_ready", 64'(md_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset.we", 64'(rf_we), 64'd0);

        // main-pipe result selection
        main_op(1'b1, 3'd0, 5'd3, 32'hDEADBEEF); step();
        chk_wr("alu", 1'b1, 5'd3, 32'hDEADBEEF);
        in_pc = 32'hFFFFFFFC; main_op(1'b1, 3'd2, 5'd1, 32'd0); step();
        chk_wr("pc_wrap", 1'b1, 5'd1, 32'h00000000);
        in_csr = 32'h55; main_op(1'b1, 3'd3, 5'd7, 32'd0); step();
        chk_wr("csr", 1'b1, 5'd7, 32'h55);
        main_op(1'b1, 3'd4, 5'd9, 32'h1111); step();
        chk_wr("sel_none_hold", 1'b0, 5'd7, 32'h55);

        // load extraction
        in_load = 32'h80FF7F01;
        main_op(1'b1, 3'd1, 5'd4, 32'd0);
        in_load_fn = 3'd0; in_addr_lo = 2'd3; step();
        chk_wr("lb_3", 1'b1, 5'd4, 32'hFFFFFF80);
        in_load_fn = 3'd5; in_addr_lo = 2'd2; step();
        chk("lhu_2", 64'(rf_wdata), 64'h000080FF);
        in_load_fn = 3'd1; in_addr_lo = 2'd0; step();
        chk("lh_0", 64'(rf_wdata), 64'h00007F01);
        in_load_fn = 3'd4; in_addr_lo = 2'd1; step();
        chk("lbu_1", 64'(rf_wdata), 64'h0000007F);
        in_load_fn = 3'd2; in_addr_lo = 2'd0; step();
        chk("lw", 64'(rf_wdata), 64'h80FF7F01);
        in_load_fn = 3'd3; step();
        chk("ld_bad_fn", 64'(rf_wdata), 64'h0);

        // single late beat with main idle: visible two edges after handshake
        main_op(1'b0, 3'd4, 5'd0, 32'd0);
        md_op(1'b1, 5'd5, 32'h1234); step();
        md_op(1'b0, 5'd0, 32'd0);
        chk("md_lat1.we", 64'(rf_we), 64'd0);
        step();
        chk_wr("md_lat2", 1'b1, 5'd5, 32'h1234);
        step();
        chk("md_idle.we", 64'(rf_we), 64'd0);

        // main busy every cycle while three late beats arrive
        main_op(1'b1, 3'd0, 5'd10, 32'hA0); md_op(1'b1, 5'd11, 32'hB0); step();
        chk_wr("bp_c0", 1'b1, 5'd10, 32'hA0);
        main_op(1'b1, 3'd0, 5'd10, 32'hA1); md_op(1'b1, 5'd12, 32'hB1); step();
        chk_wr("bp_c1", 1'b1, 5'd10, 32'hA1);
        chk("bp_full.in_ready", 64'(in_ready), 64'd0);
        chk("bp_full.md_ready", 64'(md_ready), 64'd0);
        main_op(1'b1, 3'd0, 5'd10, 32'hA2); md_op(1'b1, 5'd13, 32'hB2); step();
        chk_wr("bp_drain0", 1'b1, 5'd11, 32'hB0);
        chk("bp_c3.in_ready", 64'(in_ready), 64'd1);
        chk("bp_c3.md_ready", 64'(md_ready), 64'd1);
        step();
        chk_wr("bp_c3", 1'b1, 5'd10, 32'hA2);
        md_op(1'b0, 5'd0, 32'd0);
        chk("bp_c4.in_ready", 64'(in_ready), 64'd0);
        main_op(1'b1, 3'd0, 5'd10, 32'hA3); step();
        chk_wr("bp_drain1", 1'b1, 5'd12, 32'hB1);
        step();
        chk_wr("bp_c5", 1'b1, 5'd10, 32'hA3);
        main_op(1'b0, 3'd4, 5'd0, 32'd0); step();
        chk_wr("bp_drain2", 1'b1, 5'd13, 32'hB2);
        step();
        chk("bp_empty.we", 64'(rf_we), 64'd0);

        // rd==0 main op: no write, queue head takes the port
        md_op(1'b1, 5'd20, 32'h77); step();
        md_op(1'b0, 5'd0, 32'd0);
        main_op(1'b1, 3'd0, 5'd0, 32'h999); step();
        chk_wr("rd0_drain", 1'b1, 5'd20, 32'h77);
        step();
        chk_wr("rd0_empty", 1'b0, 5'd20, 32'h77);

        // reset while the queue is full
        main_op(1'b1, 3'd0, 5'd1, 32'hC0); md_op(1'b1, 5'd21, 32'hD0); step();
        main_op(1'b1, 3'd0, 5'd1, 32'hC1); md_op(1'b1, 5'd22, 32'hD1); step();
        chk("rst_pre.md_ready", 64'(md_ready), 64'd0);
        main_op(1'b0, 3'd4, 5'd0, 32'd0); md_op(1'b0, 5'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_wr("rst_mid", 1'b0, 5'd0, 32'd0);
        chk("rst_mid.md_ready", 64'(md_ready), 64'd1);
        chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_wr($sformatf("rst_stale%0d", i), 1'b0, 5'd0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
